// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared unit-class constants, clog2 helper and entry type for rs_pool
package rs_pkg;
    localparam int ASB   = 0;
    localparam int LOGIC = 1;
    localparam int LOAD  = 2;
    localparam int STORE = 3;
    localparam int ENV   = 4;

    localparam int RS_BWIDTH = 57;
    localparam int RS_TAGW   = 6;

    // Never returns less than 1 so derived port widths stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [RS_BWIDTH-1:0] bundle;
        logic [RS_TAGW-1:0]   rs1;
        logic [RS_TAGW-1:0]   rs2;
        logic                 rdy1;
        logic                 rdy2;
    } rs_entry_t;
endpackage

// File: rtl/rs_unit_queue.sv
// rtl/rs_unit_queue.sv - one age-ordered collapsing queue with wakeup CAM and oldest-ready select
module rs_unit_queue
    import rs_pkg::*;
#(
    parameter int BWIDTH = 57,
    parameter int IW     = 4,
    parameter int DEPTH  = 4,
    parameter int TAGW   = 6,
    parameter int WAKE   = 5,
    parameter int CW     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic [IW-1:0]        i_ins_valid,
    input  logic [IW*BWIDTH-1:0] i_ins_bundle,
    input  logic [IW*TAGW-1:0]   i_ins_rs1,
    input  logic [IW*TAGW-1:0]   i_ins_rs2,
    input  logic [IW-1:0]        i_ins_rdy1,
    input  logic [IW-1:0]        i_ins_rdy2,
    input  logic [WAKE-1:0]      i_wake_valid,
    input  logic [WAKE*TAGW-1:0] i_wake_tag,
    output logic                 o_iss_valid,
    output logic [BWIDTH-1:0]    o_iss_bundle,
    input  logic                 i_iss_ready,
    output logic [CW-1:0]        o_count
);
    typedef struct packed {
        logic              valid;
        logic [BWIDTH-1:0] bundle;
        logic [TAGW-1:0]   rs1;
        logic [TAGW-1:0]   rs2;
        logic              rdy1;
        logic              rdy2;
    } entry_t;

    entry_t            q [DEPTH];
    entry_t            w [DEPTH];
    entry_t            n [DEPTH];
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [BWIDTH-1:0] last_q;
    logic              found;
    logic              fire;
    int                sel;
    int                base;
    int                k;

    function automatic logic woken(input logic [TAGW-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE; p++)
            if (i_wake_valid[p] && i_wake_tag[p*TAGW +: TAGW] == tag) hit = 1'b1;
        return hit;
    endfunction

    always_comb begin
        found = 1'b0;
        sel   = 0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (q[i].valid && q[i].rdy1 && q[i].rdy2) begin
                found = 1'b1;
                sel   = i;
            end
        fire = found & i_iss_ready;

        for (int i = 0; i < DEPTH; i++) begin
            w[i] = q[i];
            if (q[i].valid) begin
                w[i].rdy1 = q[i].rdy1 | woken(q[i].rs1);
                w[i].rdy2 = q[i].rdy2 | woken(q[i].rs2);
            end
        end

        // Entries above the fired slot slide down one place to keep age order.
        for (int i = 0; i < DEPTH; i++) begin
            n[i] = '0;
            if (fire && i >= sel) begin
                if (i + 1 < DEPTH) n[i] = w[(i + 1) % DEPTH];
            end else begin
                n[i] = w[i];
            end
        end

        base = int'(count_q) - int'(fire);
        k    = 0;
        for (int l = 0; l < IW; l++)
            if (i_ins_valid[l] && (base + k) < DEPTH) begin
                n[base + k].valid  = 1'b1;
                n[base + k].bundle = i_ins_bundle[l*BWIDTH +: BWIDTH];
                n[base + k].rs1    = i_ins_rs1[l*TAGW +: TAGW];
                n[base + k].rs2    = i_ins_rs2[l*TAGW +: TAGW];
                n[base + k].rdy1   = i_ins_rdy1[l] | (i_ins_rs1[l*TAGW +: TAGW] == '0)
                                     | woken(i_ins_rs1[l*TAGW +: TAGW]);
                n[base + k].rdy2   = i_ins_rdy2[l] | (i_ins_rs2[l*TAGW +: TAGW] == '0)
                                     | woken(i_ins_rs2[l*TAGW +: TAGW]);
                k++;
            end
        count_d = CW'(base + k);

        o_iss_valid  = found;
        o_iss_bundle = found ? q[sel].bundle : last_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            if (found) last_q <= q[sel].bundle;
            if (i_flush) begin
                for (int i = 0; i < DEPTH; i++) q[i] <= '0;
                count_q <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) q[i] <= n[i];
                count_q <= count_d;
            end
        end
    end

    assign o_count = count_q;
endmodule

// File: rtl/rs_pool.sv
// rtl/rs_pool.sv - multi-unit reservation station: lane routing, insert gating and flush fan-out
module rs_pool
    import rs_pkg::*;
#(
    parameter int BWIDTH = 57,
    parameter int IW     = 4,
    parameter int UNITS  = 5,
    parameter int DEPTH  = 4,
    parameter int TAGW   = 6,
    parameter int WAKE   = 5,
    localparam int UW    = clog2(UNITS),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic [IW-1:0]           i_ins_valid,
    input  logic [IW*BWIDTH-1:0]    i_ins_bundle,
    input  logic [IW*UW-1:0]        i_ins_unit,
    input  logic [IW*TAGW-1:0]      i_ins_rs1,
    input  logic [IW*TAGW-1:0]      i_ins_rs2,
    input  logic [IW-1:0]           i_ins_rdy1,
    input  logic [IW-1:0]           i_ins_rdy2,
    output logic                    o_ins_ready,
    input  logic [WAKE-1:0]         i_wake_valid,
    input  logic [WAKE*TAGW-1:0]    i_wake_tag,
    output logic [UNITS-1:0]        o_iss_valid,
    output logic [UNITS*BWIDTH-1:0] o_iss_bundle,
    input  logic [UNITS-1:0]        i_iss_ready,
    output logic [UNITS*CW-1:0]     o_count
);
    logic [CW-1:0] cnt [UNITS];

    // Conservative: same-cycle issue never frees room for this cycle's insert.
    always_comb begin
        o_ins_ready = 1'b1;
        for (int u = 0; u < UNITS; u++)
            if (int'(cnt[u]) > DEPTH - IW) o_ins_ready = 1'b0;
    end

    for (genvar u = 0; u < UNITS; u++) begin : g_unit
        logic [IW-1:0] lane_hit;
        for (genvar l = 0; l < IW; l++) begin : g_lane
            assign lane_hit[l] = i_ins_valid[l] & o_ins_ready
                               & (i_ins_unit[l*UW +: UW] == UW'(u));
        end

        rs_unit_queue #(
            .BWIDTH(BWIDTH), .IW(IW), .DEPTH(DEPTH), .TAGW(TAGW), .WAKE(WAKE), .CW(CW)
        ) u_queue (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_flush      (i_flush),
            .i_ins_valid  (lane_hit),
            .i_ins_bundle (i_ins_bundle),
            .i_ins_rs1    (i_ins_rs1),
            .i_ins_rs2    (i_ins_rs2),
            .i_ins_rdy1   (i_ins_rdy1),
            .i_ins_rdy2   (i_ins_rdy2),
            .i_wake_valid (i_wake_valid),
            .i_wake_tag   (i_wake_tag),
            .o_iss_valid  (o_iss_valid[u]),
            .o_iss_bundle (o_iss_bundle[u*BWIDTH +: BWIDTH]),
            .i_iss_ready  (i_iss_ready[u]),
            .o_count      (cnt[u])
        );

        assign o_count[u*CW +: CW] = cnt[u];
    end
endmodule

// File: tb/tb_rs_pool.sv
// tb/tb_rs_pool.sv - self-checking bench for rs_pool: vector table plus issue scoreboard
module tb_rs_pool;
    localparam int BW = 57, IW = 4, UN = 5, DEP = 4, TW = 6, WK = 5, UW = 3, CW = 3;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_flush;
    logic [IW-1:0]      i_ins_valid;
    logic [IW*BW-1:0]   i_ins_bundle;
    logic [IW*UW-1:0]   i_ins_unit;
    logic [IW*TW-1:0]   i_ins_rs1;
    logic [IW*TW-1:0]   i_ins_rs2;
    logic [IW-1:0]      i_ins_rdy1;
    logic [IW-1:0]      i_ins_rdy2;
    logic               o_ins_ready;
    logic [WK-1:0]      i_wake_valid;
    logic [WK*TW-1:0]   i_wake_tag;
    logic [UN-1:0]      o_iss_valid;
    logic [UN*BW-1:0]   o_iss_bundle;
    logic [UN-1:0]      i_iss_ready;
    logic [UN*CW-1:0]   o_count;

    always #5 i_clk = ~i_clk;

    rs_pool #(.BWIDTH(BW), .IW(IW), .UNITS(UN), .DEPTH(DEP), .TAGW(TW), .WAKE(WK)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_ins_valid(i_ins_valid), .i_ins_bundle(i_ins_bundle), .i_ins_unit(i_ins_unit),
        .i_ins_rs1(i_ins_rs1), .i_ins_rs2(i_ins_rs2),
        .i_ins_rdy1(i_ins_rdy1), .i_ins_rdy2(i_ins_rdy2), .o_ins_ready(o_ins_ready),
        .i_wake_valid(i_wake_valid), .i_wake_tag(i_wake_tag),
        .o_iss_valid(o_iss_valid), .o_iss_bundle(o_iss_bundle),
        .i_iss_ready(i_iss_ready), .o_count(o_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [BW-1:0] sbq [UN][$];

    typedef struct {
        logic [UW-1:0] unit;
        logic [TW-1:0] rs1;
        logic          rdy1;
        logic          wv;
        logic [TW-1:0] wtag;
        logic [BW-1:0] bundle;
        logic          exp;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] bundle_of(input int u);
        return o_iss_bundle[u*BW +: BW];
    endfunction

    function automatic logic [CW-1:0] count_of(input int u);
        return o_count[u*CW +: CW];
    endfunction

    task automatic clear_in();
        i_flush = 1'b0; i_ins_valid = '0; i_ins_bundle = '0; i_ins_unit = '0;
        i_ins_rs1 = '0; i_ins_rs2 = '0; i_ins_rdy1 = '0; i_ins_rdy2 = '0;
        i_wake_valid = '0; i_wake_tag = '0; i_iss_ready = '0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // rs2 is always tag 0 and not marked ready, so every issue also relies on tag-0 readiness.
    task automatic set_lane(input int l, input int u, input logic [BW-1:0] b,
                            input logic [TW-1:0] rs1, input logic rdy1);
        i_ins_valid[l]            = 1'b1;
        i_ins_unit[l*UW +: UW]    = UW'(u);
        i_ins_bundle[l*BW +: BW]  = b;
        i_ins_rs1[l*TW +: TW]     = rs1;
        i_ins_rdy1[l]             = rdy1;
    endtask

    task automatic wake(input int p, input logic [TW-1:0] tag);
        i_wake_valid[p]        = 1'b1;
        i_wake_tag[p*TW +: TW] = tag;
    endtask

    task automatic expect_fire(input int u, input logic [BW-1:0] b);
        sbq[u].push_back(b);
        i_iss_ready[u] = 1'b1;
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            for (int u = 0; u < UN; u++) begin
                if (o_iss_valid[u] && i_iss_ready[u]) begin
                    if (sbq[u].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_unexpected_u%0d: got %0h expected no issue", u, bundle_of(u));
                    end else begin
                        chk($sformatf("sb_issue_u%0d", u), 64'(bundle_of(u)), 64'(sbq[u].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        vt[0] = '{3'd1, 6'd0,  1'b1, 1'b0, 6'd0, 57'h1AB, 1'b1};
        vt[1] = '{3'd0, 6'd7,  1'b0, 1'b0, 6'd0, 57'h2,   1'b0};
        vt[2] = '{3'd0, 6'd9,  1'b0, 1'b1, 6'd9, 57'h3,   1'b1};
        vt[3] = '{3'd4, 6'd0,  1'b0, 1'b0, 6'd0, 57'h4,   1'b1};
        vt[4] = '{3'd6, 6'd5,  1'b1, 1'b0, 6'd0, 57'h5,   1'b0};
        vt[5] = '{3'd2, 6'd8,  1'b0, 1'b1, 6'd9, 57'h6,   1'b0};

        clear_in();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        chk("rst_iss_valid", 64'(o_iss_valid), 64'd0);
        chk("rst_iss_bundle", 64'(|o_iss_bundle), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_ins_ready", 64'(o_ins_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            clear_in();
            set_lane(0, int'(vt[i].unit), vt[i].bundle, vt[i].rs1, vt[i].rdy1);
            if (vt[i].wv) wake(i % WK, vt[i].wtag);
            tick();
            clear_in();
            if (int'(vt[i].unit) < UN) begin
                chk($sformatf("vec%0d_valid", i), 64'(o_iss_valid[vt[i].unit]), 64'(vt[i].exp));
                chk($sformatf("vec%0d_count", i), 64'(count_of(int'(vt[i].unit))), 64'd1);
                if (vt[i].exp) begin
                    expect_fire(int'(vt[i].unit), vt[i].bundle);
                    tick();
                    clear_in();
                    chk($sformatf("vec%0d_drained", i), 64'(count_of(int'(vt[i].unit))), 64'd0);
                    chk($sformatf("vec%0d_hold", i), 64'(bundle_of(int'(vt[i].unit))), 64'(vt[i].bundle));
                end else begin
                    i_flush = 1'b1;
                    tick();
                    clear_in();
                    chk($sformatf("vec%0d_flushed", i), 64'(o_count), 64'd0);
                end
            end else begin
                chk($sformatf("vec%0d_drop_count", i), 64'(o_count), 64'd0);
                chk($sformatf("vec%0d_drop_valid", i), 64'(o_iss_valid), 64'd0);
            end
        end

        // Late wakeup on port 3.
        clear_in();
        set_lane(0, 0, 57'h70, 6'd7, 1'b0);
        tick(); clear_in();
        chk("wake_wait", 64'(o_iss_valid[0]), 64'd0);
        wake(3, 6'd7);
        tick(); clear_in();
        chk("wake_valid", 64'(o_iss_valid[0]), 64'd1);
        expect_fire(0, 57'h70);
        tick(); clear_in();

        // Age order: A,B,C,D waiting; wake D then B.
        set_lane(0, 2, 57'hA, 6'd10, 1'b0);
        set_lane(1, 2, 57'hB, 6'd11, 1'b0);
        set_lane(2, 2, 57'hC, 6'd12, 1'b0);
        set_lane(3, 2, 57'hD, 6'd13, 1'b0);
        tick(); clear_in();
        chk("age_count4", 64'(count_of(2)), 64'd4);
        chk("age_wait", 64'(o_iss_valid[2]), 64'd0);
        chk("age_full_ready", 64'(o_ins_ready), 64'd0);
        wake(0, 6'd13);
        tick(); clear_in();
        chk("age_d_sel", 64'(bundle_of(2)), 64'hD);
        expect_fire(2, 57'hD);
        wake(1, 6'd11);
        tick(); clear_in();
        chk("age_b_sel", 64'(bundle_of(2)), 64'hB);
        expect_fire(2, 57'hB);
        tick(); clear_in();
        chk("age_count2", 64'(count_of(2)), 64'd2);
        chk("age_ac_wait", 64'(o_iss_valid[2]), 64'd0);
        wake(2, 6'd10);
        wake(4, 6'd12);
        tick(); clear_in();
        expect_fire(2, 57'hA);
        tick(); clear_in();
        expect_fire(2, 57'hC);
        tick(); clear_in();
        chk("age_empty", 64'(count_of(2)), 64'd0);

        // Backpressure: one STORE entry blocks all inserts.
        set_lane(0, 3, 57'h33, 6'd0, 1'b1);
        tick(); clear_in();
        chk("bp_ready_low", 64'(o_ins_ready), 64'd0);
        for (int l = 0; l < IW; l++) set_lane(l, 1, 57'(64'h100 + l), 6'd0, 1'b1);
        tick();
        chk("bp_held", 64'(count_of(1)), 64'd0);
        expect_fire(3, 57'h33);
        tick();
        i_iss_ready = '0;
        chk("bp_ready_back", 64'(o_ins_ready), 64'd1);
        chk("bp_still_held", 64'(count_of(1)), 64'd0);
        tick(); clear_in();
        chk("bp_accepted", 64'(count_of(1)), 64'd4);
        for (int l = 0; l < IW; l++) begin
            expect_fire(1, 57'(64'h100 + l));
            tick();
        end
        clear_in();
        chk("bp_drained", 64'(count_of(1)), 64'd0);

        // Collapse: [A waiting, B ready, C ready], fire B.
        set_lane(0, 0, 57'h1A, 6'd20, 1'b0);
        set_lane(1, 0, 57'h1B, 6'd0, 1'b1);
        set_lane(2, 0, 57'h1C, 6'd0, 1'b1);
        tick(); clear_in();
        chk("col_sel_b", 64'(bundle_of(0)), 64'h1B);
        expect_fire(0, 57'h1B);
        tick(); clear_in();
        chk("col_count2", 64'(count_of(0)), 64'd2);
        chk("col_sel_c", 64'(bundle_of(0)), 64'h1C);
        wake(0, 6'd20);
        tick(); clear_in();
        chk("col_a_first", 64'(bundle_of(0)), 64'h1A);
        expect_fire(0, 57'h1A);
        tick(); clear_in();
        expect_fire(0, 57'h1C);
        tick(); clear_in();
        chk("col_empty", 64'(count_of(0)), 64'd0);

        // Flush beats four inserts and a wake.
        set_lane(0, 0, 57'h40, 6'd0, 1'b1);
        set_lane(1, 1, 57'h41, 6'd30, 1'b0);
        set_lane(2, 2, 57'h42, 6'd0, 1'b1);
        set_lane(3, 4, 57'h43, 6'd0, 1'b1);
        wake(0, 6'd30);
        i_flush = 1'b1;
        tick(); clear_in();
        chk("flush_count", 64'(o_count), 64'd0);
        chk("flush_valid", 64'(o_iss_valid), 64'd0);
        chk("flush_ready", 64'(o_ins_ready), 64'd1);

        // Asynchronous reset in the middle of a cycle.
        set_lane(0, 1, 57'h77, 6'd0, 1'b1);
        tick(); clear_in();
        chk("arst_pre_valid", 64'(o_iss_valid[1]), 64'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_valid", 64'(o_iss_valid), 64'd0);
        chk("arst_bundle", 64'(|o_iss_bundle), 64'd0);
        chk("arst_count", 64'(o_count), 64'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        tick();

        for (int u = 0; u < UN; u++)
            chk($sformatf("sb_left_u%0d", u), 64'(sbq[u].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
